// File: rtl/rr_fifo_arbiter_pkg.sv
// Shared constants and the rotating-priority scan used by the arbiter.
package rr_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;

  // Widest requester set the scan function supports; callers zero-extend.
  localparam int MAXN  = 32;
  localparam int MAXSW = 5;

  // Scan (last+1) .. (last+n) mod n and return {found, idx} of the first
  // set bit in valid. Bits at or above n are ignored.
  function automatic logic [MAXSW:0] rr_pick(input logic [MAXN-1:0] valid,
                                             input int unsigned      last,
                                             input int unsigned      n);
    logic             found;
    logic [MAXSW-1:0] sel;
    int unsigned      idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= MAXN; k++) begin
      if (k <= int'(n)) begin
        idx = (last + k) % n;
        if (!found && valid[idx]) begin
          found = 1'b1;
          sel   = MAXSW'(idx);
        end
      end
    end
    return {found, sel};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: head_data always shows the
// oldest entry; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo_fwft #(
  parameter int W     = 10,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // Guard the strobes so a misbehaving caller can never over/underflow.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  // Head and status flags.
  always_comb begin
    head_data = mem[rptr[AW-1:0]];
    full      = (count == (AW+1)'(DEPTH));
    empty     = (count == '0);
  end

  // Count-derived flags must agree with the pointer wrap-bit rule.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (full  == ((wptr ^ rptr) == {1'b1, {AW{1'b0}}}));
      assert (empty == (wptr == rptr));
      assert (count <= (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters;
// each accepted word is tagged with its source index.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. req_ready depends only on req_valid, full and the last grant
// (never on out_ready); requesters hold req_data stable while waiting and
// may drop valid without a grant. out_valid/out_data/out_src is FWFT.
module rr_fifo_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int SW   = $clog2(NREQ),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [SW-1:0]      out_src,
  input  logic               out_ready,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);

  logic [SW-1:0]    last_grant;
  logic [MAXN-1:0]  valid_ext;
  logic [MAXSW:0]   pick;
  logic             push;
  logic [SW-1:0]    grant_idx;
  logic [SW+DW-1:0] push_data;
  logic [SW+DW-1:0] head_data;
  logic             pop;

  // Grant: first valid requester after last_grant, suppressed when full.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = req_valid;
    pick                  = rr_pick(valid_ext, int'(last_grant), NREQ);
    grant_idx             = pick[SW-1:0];
    push                  = pick[MAXSW] && !full;
    req_ready             = push ? (NREQ'(1) << grant_idx) : '0;
    push_data             = {grant_idx, req_data[grant_idx*DW +: DW]};
    out_valid             = !empty;
    pop                   = out_valid && out_ready;
    out_src               = head_data[SW+DW-1:DW];
    out_data              = head_data[DW-1:0];
  end

  // Priority pointer: moves only on an accepted push.
  always_ff @(posedge clk) begin
    if (reset)     last_grant <= SW'(NREQ - 1);
    else if (push) last_grant <= grant_idx;
  end

  sync_fifo_fwft #(
    .W     (SW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Structural invariants of the grant and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(req_ready));
      assert (!(full && req_ready != '0));
      assert (!(empty && out_valid));
      assert (count <= CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Bench for rr_fifo_arbiter: directed scenarios then random traffic, all
// compared against a queue-based reference model.
module tb_rr_fifo_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SW    = $clog2(NREQ);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [SW-1:0]      out_src;
  logic               out_ready;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as {src, data} and last granted index.
  logic [SW+DW-1:0] exp_q[$];
  int               lg;

  rr_fifo_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Synchronous reset for one edge; model forgets everything.
  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    lg = NREQ - 1;
  endtask

  // One clock of stimulus: drive, check against model, advance model.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                       input logic r, output logic [NREQ-1:0] rr_obs);
    int            gi;
    logic [NREQ-1:0] eg;
    logic          ep;
    int            n;
    req_valid = v;
    req_data  = d;
    out_ready = r;
    #1;
    n  = exp_q.size();
    gi = -1;
    if (n < DEPTH) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (lg + k) % NREQ;
        if (gi < 0 && v[idx]) gi = idx;
      end
    end
    eg = (gi >= 0) ? NREQ'(1 << gi) : '0;
    rr_obs = req_ready;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("count",     32'(count),     32'(n));
    chk("full",      32'(full),      32'(n == DEPTH));
    chk("empty",     32'(empty),     32'(n == 0));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    if (n != 0) begin
      chk("out_src",  32'(out_src),  32'(exp_q[0][SW+DW-1:DW]));
      chk("out_data", 32'(out_data), 32'(exp_q[0][DW-1:0]));
    end
    ep = r && (n != 0);
    @(posedge clk);
    if (ep) void'(exp_q.pop_front());
    if (gi >= 0) begin
      exp_q.push_back({SW'(gi), d[gi*DW +: DW]});
      lg = gi;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [NREQ-1:0] rr;
    int guard;
    int thr;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    lg        = NREQ - 1;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);

    // 1: all requesters, consumer stalled -> fill in order 0,1,2,3,...
    for (int i = 0; i < DEPTH; i++) cycle(4'b1111, 32'hA3A2A1A0, 1'b0, rr);
    cycle(4'b1111, 32'hA3A2A1A0, 1'b0, rr);
    chk("s1_full_ready", 32'(rr), 32'd0);
    chk("s1_full",  32'(full),  32'd1);
    chk("s1_count", 32'(count), 32'd16);

    // 2: drain with idle requesters
    chk("s2_head_src",  32'(out_src),  32'd0);
    chk("s2_head_data", 32'(out_data), 32'hA0);
    for (int i = 0; i < DEPTH; i++) cycle(4'b0000, '0, 1'b1, rr);
    chk("s2_empty", 32'(empty), 32'd1);
    chk("s2_valid", 32'(out_valid), 32'd0);
    cycle(4'b0000, '0, 1'b1, rr);

    // 3: req 2 alone three times, then 1 and 3 contend -> 3 wins
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, 32'h00550000, 1'b0, rr);
      chk("s3_req2", 32'(rr), 32'b0100);
    end
    cycle(4'b1010, 32'hB3B2B1B0, 1'b0, rr);
    chk("s3_rot_first", 32'(rr), 32'b1000);
    cycle(4'b1010, 32'hB3B2B1B0, 1'b0, rr);
    chk("s3_rot_second", 32'(rr), 32'b0010);

    // 4: one entry, push and pop together
    guard = 0;
    while (exp_q.size() > 1 && guard < 64) begin
      cycle(4'b0000, '0, 1'b1, rr);
      guard++;
    end
    chk("s4_one", 32'(count), 32'd1);
    cycle(4'b0001, 32'h00000077, 1'b1, rr);
    chk("s4_count", 32'(count), 32'd1);
    chk("s4_src",   32'(out_src),  32'd0);
    chk("s4_data",  32'(out_data), 32'h77);

    // 5: full with pop -> no bypass; grant follows next cycle
    guard = 0;
    while (exp_q.size() < DEPTH && guard < 64) begin
      cycle(4'b1111, $urandom, 1'b0, rr);
      guard++;
    end
    chk("s5_fill", 32'(full), 32'd1);
    cycle(4'b0010, 32'h0000C100, 1'b1, rr);
    chk("s5_nobypass", 32'(rr), 32'd0);
    chk("s5_count15",  32'(count), 32'd15);
    cycle(4'b0010, 32'h0000C100, 1'b0, rr);
    chk("s5_grant", 32'(rr), 32'b0010);
    chk("s5_count16", 32'(count), 32'd16);

    // 6: reset with 7 entries buffered
    do_reset();
    for (int i = 0; i < 7; i++) cycle(4'b1111, $urandom, 1'b0, rr);
    chk("s6_seven", 32'(count), 32'd7);
    do_reset();
    chk("s6_count", 32'(count), 32'd0);
    chk("s6_valid", 32'(out_valid), 32'd0);
    cycle(4'b1111, 32'hD3D2D1D0, 1'b0, rr);
    chk("s6_first", 32'(rr), 32'b0001);

    // Random traffic: low then high drain rate to hit full and empty
    for (int i = 0; i < 600; i++) begin
      thr = (i < 300) ? 30 : 80;
      cycle(NREQ'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 99) < thr), rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
